// File: rtl/csr_trap_sequencer_pkg.sv
// Shared definitions for the CSR trap/MRET sequencer: XLEN encodings,
// machine-mode CSR addresses, mstatus field positions, mtvec modes and
// the sequencer state encoding.
package csr_trap_sequencer_pkg;

    localparam logic [1:0] XLEN_32B  = 2'd1;
    localparam logic [1:0] XLEN_64B  = 2'd2;
    localparam logic [1:0] XLEN_128B = 2'd3;

    localparam logic [11:0] REG_MSTATUS_ADDR = 12'h300;
    localparam logic [11:0] REG_MTVEC_ADDR   = 12'h305;
    localparam logic [11:0] REG_MEPC_ADDR    = 12'h341;
    localparam logic [11:0] REG_MCAUSE_ADDR  = 12'h342;
    localparam logic [11:0] REG_MTVAL_ADDR   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_W_MEPC      = 3'd1,
        ST_W_MCAUSE    = 3'd2,
        ST_W_MTVAL     = 3'd3,
        ST_W_MSTATUS_T = 3'd4,
        ST_W_MSTATUS_R = 3'd5,
        ST_REDIRECT    = 3'd6
    } seq_state_t;

    // Data width for a 2-bit XLEN encoding: 1 -> 32, 2 -> 64, 3 -> 128.
    function automatic int xlen_width(input logic [1:0] xlen);
        return 1 << (int'(xlen) + 4);
    endfunction

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// Request/CSR-write/redirect bundle for the trap sequencer.
// master: hazard/exception unit + CSR file side; slave: the sequencer.
interface csr_trap_sequencer_if #(
    parameter int W = 64
);
    logic           i_trap_req;
    logic           i_trap_is_irq;
    logic [4:0]     i_trap_code;
    logic [W-1:0]   i_trap_pc;
    logic [W-1:0]   i_trap_tval;
    logic           i_mret_req;
    logic [W-1:0]   i_mstatus;
    logic [W-1:0]   i_mtvec;
    logic [W-1:0]   i_mepc;

    logic           o_ack;
    logic           o_busy;
    logic           o_csr_we;
    logic [11:0]    o_csr_waddr;
    logic [W-1:0]   o_csr_wdata;
    logic           o_redirect;
    logic [W-1:0]   o_redirect_pc;

    modport master (
        output i_trap_req, i_trap_is_irq, i_trap_code, i_trap_pc, i_trap_tval,
        output i_mret_req, i_mstatus, i_mtvec, i_mepc,
        input  o_ack, o_busy, o_csr_we, o_csr_waddr, o_csr_wdata,
        input  o_redirect, o_redirect_pc
    );

    modport slave (
        input  i_trap_req, i_trap_is_irq, i_trap_code, i_trap_pc, i_trap_tval,
        input  i_mret_req, i_mstatus, i_mtvec, i_mepc,
        output o_ack, o_busy, o_csr_we, o_csr_waddr, o_csr_wdata,
        output o_redirect, o_redirect_pc
    );

endinterface

// File: rtl/csr_trap_sequencer_target.sv
// trap_target_calc: combinational trap vector from mtvec.
// Vectored mode offsets interrupts by code*4; exceptions and any other
// mode (including the reserved 2'b1x) go to the aligned base.
module trap_target_calc
    import csr_trap_sequencer_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] mtvec,
    input  logic         irq,
    input  logic [4:0]   code,
    output logic [W-1:0] target
);

    logic [W-1:0] base;

    // Aligned base and optional vector offset; overflow wraps at W bits.
    always_comb begin
        base   = mtvec & ~W'(3);
        target = base;
        if ((mtvec[1:0] == MTVEC_MODE_VECTORED) && irq) begin
            target = base + (W'(code) << 2);
        end
    end

endmodule

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: drives the machine-mode CSR write port on trap
// entry (mepc, mcause, [mtval], mstatus) and on MRET (mstatus), then
// issues a one-cycle PC redirect. Outputs are registered, so each write
// appears the cycle after its state.
// Build option: CSR_TRAP_MTVAL_EN adds the mtval write to the trap path.
//
// state          | meaning
// ST_IDLE        | waiting; trap has priority over mret
// ST_W_MEPC      | write faulting pc (word aligned) to mepc
// ST_W_MCAUSE    | write {irq, code} to mcause
// ST_W_MTVAL     | write trap value to mtval (only with CSR_TRAP_MTVAL_EN)
// ST_W_MSTATUS_T | trap-entry mstatus update
// ST_W_MSTATUS_R | mret mstatus update
// ST_REDIRECT    | pulse redirect to latched target
module csr_trap_sequencer
    import csr_trap_sequencer_pkg::*;
#(
    parameter logic [1:0] XLEN = XLEN_64B
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    csr_trap_sequencer_if.slave  bus
);

    localparam int W = xlen_width(XLEN);

    seq_state_t     state;
    logic           lat_irq;
    logic [4:0]     lat_code;
    logic [W-1:0]   lat_pc;
`ifdef CSR_TRAP_MTVAL_EN
    logic [W-1:0]   lat_tval;
`endif
    logic [W-1:0]   lat_target;
    logic [W-1:0]   trap_target;

    logic           ack_q;
    logic           we_q;
    logic [11:0]    waddr_q;
    logic [W-1:0]   wdata_q;
    logic           redirect_q;
    logic [W-1:0]   redirect_pc_q;

    trap_target_calc #(.W(W)) u_target (
        .mtvec  (bus.i_mtvec),
        .irq    (bus.i_trap_is_irq),
        .code   (bus.i_trap_code),
        .target (trap_target)
    );

    function automatic logic [W-1:0] mstatus_on_trap(input logic [W-1:0] m);
        logic [W-1:0] r;
        r = m;
        r[MSTATUS_MPIE] = m[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // M-only core: MPP always returns to M.
    function automatic logic [W-1:0] mstatus_on_mret(input logic [W-1:0] m);
        logic [W-1:0] r;
        r = m;
        r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [W-1:0] mcause_value(input logic irq, input logic [4:0] code);
        logic [W-1:0] r;
        r = '0;
        r[W-1] = irq;
        r[4:0] = code;
        return r;
    endfunction

    // Sequencer FSM with registered outputs; outputs default to 0 each cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            lat_irq       <= 1'b0;
            lat_code      <= '0;
            lat_pc        <= '0;
`ifdef CSR_TRAP_MTVAL_EN
            lat_tval      <= '0;
`endif
            lat_target    <= '0;
            ack_q         <= 1'b0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            ack_q         <= 1'b0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.i_trap_req) begin
                        ack_q      <= 1'b1;
                        lat_irq    <= bus.i_trap_is_irq;
                        lat_code   <= bus.i_trap_code;
                        lat_pc     <= bus.i_trap_pc;
`ifdef CSR_TRAP_MTVAL_EN
                        lat_tval   <= bus.i_trap_tval;
`endif
                        lat_target <= trap_target;
                        state      <= ST_W_MEPC;
                    end else if (bus.i_mret_req) begin
                        ack_q      <= 1'b1;
                        lat_target <= bus.i_mepc;
                        state      <= ST_W_MSTATUS_R;
                    end
                end
                ST_W_MEPC: begin
                    we_q    <= 1'b1;
                    waddr_q <= REG_MEPC_ADDR;
                    wdata_q <= lat_pc & ~W'(3);
                    state   <= ST_W_MCAUSE;
                end
                ST_W_MCAUSE: begin
                    we_q    <= 1'b1;
                    waddr_q <= REG_MCAUSE_ADDR;
                    wdata_q <= mcause_value(lat_irq, lat_code);
`ifdef CSR_TRAP_MTVAL_EN
                    state   <= ST_W_MTVAL;
`else
                    state   <= ST_W_MSTATUS_T;
`endif
                end
                ST_W_MTVAL: begin
`ifdef CSR_TRAP_MTVAL_EN
                    we_q    <= 1'b1;
                    waddr_q <= REG_MTVAL_ADDR;
                    wdata_q <= lat_tval;
                    state   <= ST_W_MSTATUS_T;
`else
                    state   <= ST_IDLE;
`endif
                end
                ST_W_MSTATUS_T: begin
                    we_q    <= 1'b1;
                    waddr_q <= REG_MSTATUS_ADDR;
                    wdata_q <= mstatus_on_trap(bus.i_mstatus);
                    state   <= ST_REDIRECT;
                end
                ST_W_MSTATUS_R: begin
                    we_q    <= 1'b1;
                    waddr_q <= REG_MSTATUS_ADDR;
                    wdata_q <= mstatus_on_mret(bus.i_mstatus);
                    state   <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= lat_target;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ack         = ack_q;
    assign bus.o_busy        = (state != ST_IDLE);
    assign bus.o_csr_we      = we_q;
    assign bus.o_csr_waddr   = waddr_q;
    assign bus.o_csr_wdata   = wdata_q;
    assign bus.o_redirect    = redirect_q;
    assign bus.o_redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Self-checking bench for csr_trap_sequencer (64-bit build). Expected
// write lists, redirect latency and target come from a reference model
// of the architectural trap/MRET rules.
module tb_csr_trap_sequencer;

    localparam int W = 64;
`ifdef CSR_TRAP_MTVAL_EN
    localparam bit MTVAL_EN = 1'b1;
`else
    localparam bit MTVAL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csr_trap_sequencer_if #(.W(W)) bus ();

    csr_trap_sequencer dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_addr[$];
    logic [63:0] exp_data[$];
    int          exp_lat;
    logic [63:0] exp_pc;

    logic [11:0] obs_addr[$];
    logic [63:0] obs_data[$];
    int          obs_lat;
    logic [63:0] obs_pc;
    int          ack_wait;
    bit          stray_ack;
    bit          bus_dirty;
    bit          busy_at_ack;
    bit          busy_gap;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] ref_ms_trap(input logic [63:0] m);
        logic [63:0] mie;
        mie = (m >> 3) & 64'd1;
        return (m & ~64'h1888) | (mie << 7) | 64'h1800;
    endfunction

    function automatic logic [63:0] ref_ms_mret(input logic [63:0] m);
        logic [63:0] mpie;
        mpie = (m >> 7) & 64'd1;
        return (m & ~64'h1888) | 64'h80 | 64'h1800 | (mpie << 3);
    endfunction

    task automatic model_trap(input bit irq, input logic [4:0] code, input logic [63:0] pc,
                              input logic [63:0] tval, input logic [63:0] mtvec,
                              input logic [63:0] ms);
        logic [63:0] base;
        exp_addr.delete(); exp_data.delete();
        exp_addr.push_back(12'h341); exp_data.push_back(pc & ~64'd3);
        exp_addr.push_back(12'h342); exp_data.push_back((irq ? 64'h8000_0000_0000_0000 : 64'd0) + 64'(code));
        if (MTVAL_EN) begin
            exp_addr.push_back(12'h343); exp_data.push_back(tval);
        end
        exp_addr.push_back(12'h300); exp_data.push_back(ref_ms_trap(ms));
        exp_lat = MTVAL_EN ? 5 : 4;
        base = mtvec - (mtvec % 4);
        exp_pc = ((mtvec % 4 == 1) && irq) ? base + 64'(code) * 4 : base;
    endtask

    task automatic model_mret(input logic [63:0] ms, input logic [63:0] mepc);
        exp_addr.delete(); exp_data.delete();
        exp_addr.push_back(12'h300); exp_data.push_back(ref_ms_mret(ms));
        exp_lat = 2;
        exp_pc  = mepc;
    endtask

    task automatic set_trap(input bit irq, input logic [4:0] code, input logic [63:0] pc,
                            input logic [63:0] tval, input logic [63:0] mtvec,
                            input logic [63:0] ms);
        bus.i_trap_is_irq = irq;
        bus.i_trap_code   = code;
        bus.i_trap_pc     = pc;
        bus.i_trap_tval   = tval;
        bus.i_mtvec       = mtvec;
        bus.i_mstatus     = ms;
        bus.i_trap_req    = 1'b1;
    endtask

    // Waits (bounded) for ack, drops the acked request, then records
    // writes per cycle until the redirect pulse.
    task automatic observe(input bit is_trap);
        ack_wait = 0;
        while (bus.o_ack !== 1'b1 && ack_wait < 20) begin
            @(negedge clk);
            ack_wait++;
        end
        if (is_trap) bus.i_trap_req = 1'b0;
        else         bus.i_mret_req = 1'b0;
        obs_addr.delete(); obs_data.delete();
        obs_lat = -1; obs_pc = '0;
        stray_ack = 1'b0; bus_dirty = 1'b0; busy_gap = 1'b0;
        busy_at_ack = bus.o_busy;
        for (int off = 0; off < 10; off++) begin
            if (off > 0) @(negedge clk);
            if (off > 0 && bus.o_ack) stray_ack = 1'b1;
            if (bus.o_csr_we) begin
                obs_addr.push_back(bus.o_csr_waddr);
                obs_data.push_back(bus.o_csr_wdata);
            end else if (bus.o_csr_waddr != 0 || bus.o_csr_wdata != 0) begin
                bus_dirty = 1'b1;
            end
            if (bus.o_redirect) begin
                obs_lat = off;
                obs_pc  = bus.o_redirect_pc;
                break;
            end
            if (off > 0 && !bus.o_busy) busy_gap = 1'b1;
        end
    endtask

    task automatic compare(input string tag, input int exp_ack_wait);
        int n;
        chk({tag, ".ack_wait"}, ack_wait, exp_ack_wait);
        chk({tag, ".nwrites"}, obs_addr.size(), exp_addr.size());
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.waddr%0d", tag, i), obs_addr[i], exp_addr[i]);
            chk($sformatf("%s.wdata%0d", tag, i), obs_data[i], exp_data[i]);
        end
        chk({tag, ".latency"}, obs_lat, exp_lat);
        chk({tag, ".redirect_pc"}, obs_pc, exp_pc);
        chk({tag, ".stray_ack"}, stray_ack, 1'b0);
        chk({tag, ".idle_bus_zero"}, bus_dirty, 1'b0);
        chk({tag, ".busy_at_ack"}, busy_at_ack, 1'b1);
        chk({tag, ".busy_gap"}, busy_gap, 1'b0);
    endtask

    initial begin
        bit          flag;
        int          n;
        bit          irq;
        logic [4:0]  code;
        logic [63:0] pc, tval, mtvec, ms, mepc;

        bus.i_trap_req = 0; bus.i_trap_is_irq = 0; bus.i_trap_code = '0;
        bus.i_trap_pc = '0; bus.i_trap_tval = '0; bus.i_mret_req = 0;
        bus.i_mstatus = '0; bus.i_mtvec = '0; bus.i_mepc = '0;

        repeat (3) @(negedge clk);
        chk("reset.ctrl", {bus.o_ack, bus.o_busy, bus.o_csr_we, bus.o_redirect}, 4'b0);
        chk("reset.data", {52'd0, bus.o_csr_waddr} | bus.o_csr_wdata | bus.o_redirect_pc, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset.ctrl", {bus.o_ack, bus.o_busy, bus.o_csr_we, bus.o_redirect}, 4'b0);

        // Exception, direct mode
        set_trap(1'b0, 5'd2, 64'h1002, 64'hDEAD, 64'h8000_0100, 64'h8);
        model_trap(1'b0, 5'd2, 64'h1002, 64'hDEAD, 64'h8000_0100, 64'h8);
        observe(1'b1);
        compare("exc_direct", 1);

        // Interrupt, vectored mode
        set_trap(1'b1, 5'd7, 64'h4000, 64'h0, 64'h8000_0101, 64'h8);
        model_trap(1'b1, 5'd7, 64'h4000, 64'h0, 64'h8000_0101, 64'h8);
        observe(1'b1);
        compare("irq_vectored", 1);

        // MRET
        bus.i_mstatus = 64'h1880; bus.i_mepc = 64'h2000; bus.i_mret_req = 1'b1;
        model_mret(64'h1880, 64'h2000);
        observe(1'b0);
        compare("mret", 1);

        // Simultaneous trap and mret: trap first, mret acked right after
        bus.i_mepc = 64'h3000;
        set_trap(1'b0, 5'd11, 64'h5557, 64'h77, 64'h100, 64'h88);
        bus.i_mret_req = 1'b1;
        model_trap(1'b0, 5'd11, 64'h5557, 64'h77, 64'h100, 64'h88);
        observe(1'b1);
        compare("both.trap", 1);
        model_mret(64'h88, 64'h3000);
        observe(1'b0);
        compare("both.mret", 1);

        // Reset asserted in W_MCAUSE
        set_trap(1'b0, 5'd4, 64'h9000, 64'h1, 64'h200, 64'h8);
        n = 0;
        while (bus.o_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid.ack_wait", n, 1);
        bus.i_trap_req = 1'b0;
        @(negedge clk);
        chk("rst_mid.mepc_write", {bus.o_csr_we, bus.o_busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.ctrl", {bus.o_ack, bus.o_busy, bus.o_csr_we, bus.o_redirect}, 4'b0);
        chk("rst_mid.data", {52'd0, bus.o_csr_waddr} | bus.o_csr_wdata | bus.o_redirect_pc, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_redirect || bus.o_busy || bus.o_csr_we || bus.o_ack) flag = 1'b1;
        end
        chk("rst_mid.quiet_after", flag, 1'b0);

        // Randomized traps and mrets
        for (int t = 0; t < 30; t++) begin
            ms = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) begin
                irq   = 1'($urandom_range(0, 1));
                code  = 5'($urandom);
                pc    = {$urandom, $urandom};
                tval  = {$urandom, $urandom};
                mtvec = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) mtvec = 64'hFFFF_FFFF_FFFF_FFFD;
                set_trap(irq, code, pc, tval, mtvec, ms);
                model_trap(irq, code, pc, tval, mtvec, ms);
                observe(1'b1);
                compare($sformatf("rnd%0d.trap", t), 1);
            end else begin
                mepc = {$urandom, $urandom};
                bus.i_mstatus = ms; bus.i_mepc = mepc; bus.i_mret_req = 1'b1;
                model_mret(ms, mepc);
                observe(1'b0);
                compare($sformatf("rnd%0d.mret", t), 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
